bus_dma: RTL

BUS_DMA -- requirements
Module: bus_dma

---
 rtl/bus_dma.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bus_dma.sv
// Byte-wide memory-to-memory DMA engine with a CPU register window and bus request/grant handshake.
// Optional fill mode (repeat src_l into the destination) is compiled in when DMA_FILL_EN is defined.
module bus_dma (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cs_i,
    input  logic        R_W_n,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        busreq_o,
    input  logic        busgnt_i,
    output logic [15:0] dma_addr_o,
    output logic        dma_R_W_n_o,
    output logic [7:0]  dma_data_o,
    input  logic [7:0]  dma_data_i,
    output logic        irq_o
);

    typedef enum logic [2:0] {IDLE, REQ, RD, LATCH, WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] src_q, dst_q, len_q;
    logic [15:0] len_dec;
    logic [7:0]  buf_q;
    logic        done_q, ie_q, fill_q;
    logic [2:0]  off;
    logic        busy, wr_en, reg_wr, ctrl_wr;
    logic        start_req, set_done, clr_done;
    logic        unused_bits;

    assign off       = addr_i[2:0];
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign wr_en     = cs_i & ~R_W_n;
    assign reg_wr    = wr_en & ~busy & (off <= 3'd5);
    assign ctrl_wr   = wr_en & (off == 3'd6);
    // DONE is not busy, but a start there must still be dropped, hence the IDLE test
    assign start_req = ctrl_wr & data_i[0] & (state_q == IDLE);
    assign clr_done  = ctrl_wr & data_i[7];
    assign len_dec   = len_q - 16'd1;
    assign set_done  = (start_req && (len_q == 16'd0)) ||
                       ((state_q == WR) && (len_dec == 16'd0));
    assign irq_o     = done_q & ie_q;

    assign unused_bits = ^{addr_i[15:3], data_i[6:2]};

`ifdef DMA_FILL_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_q <= 1'b0;
        end else if (ctrl_wr && !busy) begin
            fill_q <= data_i[2];
        end
    end
`else
    assign fill_q = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q  <= 16'h0000;
            dst_q  <= 16'h0000;
            len_q  <= 16'h0000;
            buf_q  <= 8'h00;
            done_q <= 1'b0;
            ie_q   <= 1'b0;
        end else begin
            // Pointer update and register writes are exclusive: WR is a busy state
            if (state_q == WR) begin
                src_q <= src_q + {15'd0, ~fill_q};
                dst_q <= dst_q + 16'd1;
                len_q <= len_dec;
            end else if (reg_wr) begin
                case (off)
                    3'd0:    src_q[7:0]  <= data_i;
                    3'd1:    src_q[15:8] <= data_i;
                    3'd2:    dst_q[7:0]  <= data_i;
                    3'd3:    dst_q[15:8] <= data_i;
                    3'd4:    len_q[7:0]  <= data_i;
                    3'd5:    len_q[15:8] <= data_i;
                    default: ;
                endcase
            end
            if (state_q == LATCH) begin
                buf_q <= dma_data_i;
            end
            if (set_done) begin
                done_q <= 1'b1;
            end else if (clr_done) begin
                done_q <= 1'b0;
            end
            // ie is frozen during a transfer like the other configuration bits
            if (ctrl_wr && !busy) begin
                ie_q <= data_i[1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busreq_o    = 1'b0;
        dma_addr_o  = 16'h0000;
        dma_R_W_n_o = 1'b1;
        dma_data_o  = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (start_req && (len_q != 16'd0)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                busreq_o = 1'b1;
                if (busgnt_i) begin
                    state_d = fill_q ? WR : RD;
                end
            end
            RD: begin
                busreq_o   = 1'b1;
                dma_addr_o = src_q;
                state_d    = LATCH;
            end
            LATCH: begin
                busreq_o = 1'b1;
                state_d  = WR;
            end
            WR: begin
                busreq_o    = 1'b1;
                dma_addr_o  = dst_q;
                dma_R_W_n_o = 1'b0;
                dma_data_o  = fill_q ? src_q[7:0] : buf_q;
                // Grant is only re-examined here, so a mid-byte drop never aborts a byte
                if (len_dec == 16'd0) begin
                    state_d = DONE;
                end else if (busgnt_i) begin
                    state_d = fill_q ? WR : RD;
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        data_o = 8'h00;
        if (cs_i && R_W_n) begin
            case (off)
                3'd0:    data_o = src_q[7:0];
                3'd1:    data_o = src_q[15:8];
                3'd2:    data_o = dst_q[7:0];
                3'd3:    data_o = dst_q[15:8];
                3'd4:    data_o = len_q[7:0];
                3'd5:    data_o = len_q[15:8];
                3'd6:    data_o = {ie_q, fill_q, 4'b0000, done_q, busy};
                default: data_o = 8'h00;
            endcase
        end
    end

endmodule
